// File: rtl/gram_frame_scheduler.sv
// SDRAM frame-buffer scheduler: one outstanding burst, 2/3-bank frame rotation.
// Optional define GRAM_FRAME_RESYNC_EN: a vsync edge aborts a partial write frame.
module gram_frame_scheduler #(
    parameter int BANK_NUM         = 3,
    parameter int ROW_W            = 13,
    parameter int COL_W            = 9,
    parameter int BURST_LEN        = 256,
    parameter int BURSTS_PER_FRAME = 1200,
    parameter int LVL_W            = 10,
    parameter int WR_THRESH        = 256,
    parameter int RD_THRESH        = 256,
    parameter int RD_URGENT        = 64,
    parameter int TIMEOUT          = 1023
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     init_done,
    input  logic [LVL_W-1:0]         in_level,
    input  logic [LVL_W-1:0]         out_level,
    input  logic                     wr_frame_sync,
    output logic                     wr_req,
    output logic [2+ROW_W+COL_W-1:0] wr_addr,
    input  logic                     wr_busy,
    output logic                     rd_req,
    output logic [2+ROW_W+COL_W-1:0] rd_addr,
    input  logic                     rd_busy,
    output logic                     wr_frame_done,
    output logic                     rd_frame_done,
    output logic [7:0]               repeat_cnt,
    output logic                     timeout_err
);
    localparam int IDX_W = (BURSTS_PER_FRAME > 1) ? $clog2(BURSTS_PER_FRAME) : 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BURSTS_PER_FRAME - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [COL_W:0]   COL_STEP = (COL_W + 1)'(BURST_LEN);

    typedef enum logic [2:0] {IDLE, REQ, WAIT_HI, WAIT_LO, DONE} state_t;

    state_t             state, state_nx;
    logic               sel_rd, sel_rd_nx, rr_rd, rr_rd_nx, grant;
    logic               busy_q, cur_busy;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [1:0]         wr_bank, rd_bank, latest, wr_bank_nx;
    logic               latest_valid;
    logic [ROW_W-1:0]   wr_row, rd_row;
    logic [COL_W-1:0]   wr_col, rd_col;
    logic [COL_W:0]     wr_col_sum, rd_col_sum;
    logic [IDX_W-1:0]   wr_idx, rd_idx;
    logic               wr_ok, rd_ok, rd_urgent;
    logic               wr_done, rd_done, wr_inflight, wr_abort;

`ifdef GRAM_FRAME_RESYNC_EN
    logic [2:0] sync_q;
    logic       sync_rise, resync_pend;

    assign sync_rise = sync_q[1] & ~sync_q[2];
    assign wr_abort  = (sync_rise && wr_idx != '0) || resync_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            resync_pend <= 1'b0;
        end else begin
            sync_q      <= {sync_q[1:0], wr_frame_sync};
            // abort seen mid-burst is deferred to that burst's DONE cycle
            resync_pend <= wr_abort && wr_inflight && !wr_done;
        end
    end
`else
    logic sync_unused;
    assign sync_unused = wr_frame_sync;
    assign wr_abort    = 1'b0;
`endif

    assign cur_busy    = sel_rd ? rd_busy : wr_busy;
    assign wr_ok       = 32'(in_level) >= WR_THRESH && !wr_busy && !wr_abort;
    assign rd_ok       = 32'(out_level) < RD_THRESH && !rd_busy;
    assign rd_urgent   = 32'(out_level) < RD_URGENT;
    assign wr_done     = state == DONE && !sel_rd;
    assign rd_done     = state == DONE && sel_rd;
    assign wr_inflight = state != IDLE && !sel_rd;
    assign wr_req      = state == REQ && !sel_rd;
    assign rd_req      = state == REQ && sel_rd;
    assign wr_col_sum  = {1'b0, wr_col} + COL_STEP;
    assign rd_col_sum  = {1'b0, rd_col} + COL_STEP;
    // three banks sum to 3, so the free one is 3 - reader - newest
    assign wr_bank_nx  = (BANK_NUM == 3) ? 2'd3 - rd_bank - wr_bank
                                         : {1'b0, ~wr_bank[0]};

    always_comb begin
        state_nx  = state;
        sel_rd_nx = sel_rd;
        rr_rd_nx  = rr_rd;
        grant     = 1'b0;
        unique case (state)
            IDLE: begin
                if (init_done && (wr_ok || rd_ok)) begin
                    grant    = 1'b1;
                    state_nx = REQ;
                    if (rd_ok && rd_urgent) begin
                        sel_rd_nx = 1'b1;
                    end else if (wr_ok && rd_ok) begin
                        sel_rd_nx = rr_rd;
                        rr_rd_nx  = ~rr_rd;
                    end else begin
                        sel_rd_nx = rd_ok;
                    end
                end
            end
            REQ:     state_nx = WAIT_HI;
            WAIT_HI: begin
                if (cur_busy)                 state_nx = WAIT_LO;
                else if (tmo_cnt == TMO_LAST) state_nx = IDLE;
            end
            WAIT_LO: if (busy_q && !cur_busy) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sel_rd <= 1'b0;
            rr_rd  <= 1'b0;
            busy_q <= 1'b0;
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
            wr_addr <= '0;
            rd_addr <= '0;
        end else begin
            state  <= state_nx;
            sel_rd <= sel_rd_nx;
            rr_rd  <= rr_rd_nx;
            busy_q <= cur_busy;
            tmo_cnt <= (state == WAIT_HI) ? tmo_cnt + 1'b1 : '0;
            if (state == WAIT_HI && !cur_busy && tmo_cnt == TMO_LAST)
                timeout_err <= 1'b1;
            if (grant && !sel_rd_nx) wr_addr <= {wr_bank, wr_row, wr_col};
            if (grant && sel_rd_nx)  rd_addr <= {rd_bank, rd_row, rd_col};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank <= '0;
            wr_row  <= '0;
            wr_col  <= '0;
            wr_idx  <= '0;
            latest  <= '0;
            latest_valid  <= 1'b0;
            wr_frame_done <= 1'b0;
        end else begin
            wr_frame_done <= 1'b0;
            if (wr_abort && (!wr_inflight || wr_done)) begin
                wr_row <= '0;
                wr_col <= '0;
                wr_idx <= '0;
            end else if (wr_done && wr_idx == IDX_LAST) begin
                latest        <= wr_bank;
                latest_valid  <= 1'b1;
                wr_frame_done <= 1'b1;
                wr_bank <= wr_bank_nx;
                wr_row  <= '0;
                wr_col  <= '0;
                wr_idx  <= '0;
            end else if (wr_done) begin
                wr_col <= wr_col_sum[COL_W-1:0];
                if (wr_col_sum[COL_W]) wr_row <= wr_row + 1'b1;
                wr_idx <= wr_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_bank <= 2'(BANK_NUM - 1);
            rd_row  <= '0;
            rd_col  <= '0;
            rd_idx  <= '0;
            repeat_cnt    <= '0;
            rd_frame_done <= 1'b0;
        end else begin
            rd_frame_done <= 1'b0;
            if (rd_done && rd_idx == IDX_LAST) begin
                rd_frame_done <= 1'b1;
                if (latest_valid && latest != rd_bank)
                    rd_bank <= latest;
                else if (repeat_cnt != 8'hFF)
                    repeat_cnt <= repeat_cnt + 1'b1;
                rd_row <= '0;
                rd_col <= '0;
                rd_idx <= '0;
            end else if (rd_done) begin
                rd_col <= rd_col_sum[COL_W-1:0];
                if (rd_col_sum[COL_W]) rd_row <= rd_row + 1'b1;
                rd_idx <= rd_idx + 1'b1;
            end
        end
    end

    if (BANK_NUM == 3) begin : g_bank_chk
        a_no_shared_bank: assert property (
            @(posedge clk) disable iff (!rst_n) rd_bank != wr_bank);
    end

endmodule

// File: tb/tb_gram_frame_scheduler.sv
// Scoreboard bench for gram_frame_scheduler (3 banks, 4 bursts per frame).
module tb_gram_frame_scheduler;
    localparam int ROW_W = 13;
    localparam int COL_W = 9;
    localparam int AW    = 2 + ROW_W + COL_W;
    localparam int BPF   = 4;
    localparam int TMO   = 1023;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init_done = 1'b0;
    logic [9:0]    in_level = '0;
    logic [9:0]    out_level = 10'd400;
    logic          wr_frame_sync = 1'b0;
    logic          wr_busy = 1'b0;
    logic          rd_busy = 1'b0;
    logic          wr_req, rd_req, wr_frame_done, rd_frame_done, timeout_err;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [7:0]    repeat_cnt;

    gram_frame_scheduler #(
        .BANK_NUM(3), .ROW_W(ROW_W), .COL_W(COL_W), .BURST_LEN(256),
        .BURSTS_PER_FRAME(BPF), .LVL_W(10), .WR_THRESH(256),
        .RD_THRESH(256), .RD_URGENT(64), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done),
        .in_level(in_level), .out_level(out_level),
        .wr_frame_sync(wr_frame_sync),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_busy(wr_busy),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_busy(rd_busy),
        .wr_frame_done(wr_frame_done), .rd_frame_done(rd_frame_done),
        .repeat_cnt(repeat_cnt), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            kind;
        logic [AW-1:0] addr;
    } ev_t;

    ev_t exp_q[$];
    int  n_pass = 0;
    int  n_tot  = 0;
    int  n_ev   = 0;
    int  busy_len = 20;
    bit  no_busy  = 1'b0;

    // kinds: 0 write req, 1 read req, 2 write frame done, 3 read frame done
    function automatic logic [AW-1:0] mk(input int b, input int r, input int c);
        return {2'(b), ROW_W'(r), COL_W'(c)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic push(input int kind, input int b, input int r, input int c);
        ev_t e;
        e.kind = kind;
        e.addr = (kind < 2) ? mk(b, r, c) : '0;
        exp_q.push_back(e);
    endtask

    // monitor: every request or frame pulse must match the queue head
    ev_t           m_e;
    int            m_k;
    logic [AW-1:0] m_a;
    initial forever begin
        @(negedge clk);
        if (rst_n && (wr_req || rd_req || wr_frame_done || rd_frame_done)) begin
            m_k = wr_req ? 0 : rd_req ? 1 : wr_frame_done ? 2 : 3;
            m_a = wr_req ? wr_addr : rd_req ? rd_addr : '0;
            n_ev++;
            if (exp_q.size() == 0) begin
                n_tot++;
                $display("FAIL event%0d: got kind %0d addr %0h, required none",
                         n_ev, m_k, m_a);
            end else begin
                m_e = exp_q.pop_front();
                chk($sformatf("event%0d_kind", n_ev), 64'(m_k), 64'(m_e.kind));
                chk($sformatf("event%0d_addr", n_ev), 64'(m_a), 64'(m_e.addr));
            end
        end
    end

    // SDRAM core model: busy rises 2 cycles after a request
    bit core_rd;
    initial forever begin
        @(negedge clk);
        if ((wr_req || rd_req) && !no_busy) begin
            core_rd = rd_req;
            repeat (2) @(negedge clk);
            if (core_rd) rd_busy = 1'b1; else wr_busy = 1'b1;
            repeat (busy_len) @(negedge clk);
            rd_busy = 1'b0;
            wr_busy = 1'b0;
        end
    end

    task automatic wait_reqs(input int n);
        int cnt = 0;
        for (int i = 0; i < 4000 && cnt < n; i++) begin
            @(negedge clk);
            if (wr_req || rd_req) cnt++;
        end
        if (cnt < n) begin
            n_tot++;
            $display("FAIL wait_reqs: got %0d requests, required %0d", cnt, n);
        end
    endtask

    task automatic burst_w(input int b, input int r, input int c, input bit last);
        push(0, b, r, c);
        if (last) push(2, 0, 0, 0);
        in_level = 10'd300;
        wait_reqs(1);
        in_level = '0;
        repeat (busy_len + 12) @(negedge clk);
    endtask

    task automatic burst_r(input int b, input int r, input int c, input bit last);
        push(1, b, r, c);
        if (last) push(3, 0, 0, 0);
        out_level = 10'd100;
        wait_reqs(1);
        out_level = 10'd400;
        repeat (busy_len + 12) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_wr_req", 64'(wr_req), 0);
        chk("rst_rd_req", 64'(rd_req), 0);
        chk("rst_wr_addr", 64'(wr_addr), 0);
        chk("rst_rd_addr", 64'(rd_addr), 0);
        chk("rst_repeat", 64'(repeat_cnt), 0);
        chk("rst_timeout", 64'(timeout_err), 0);
        chk("rst_frame_done", 64'({wr_frame_done, rd_frame_done}), 0);
        rst_n = 1'b1;

        in_level = 10'd300;
        repeat (20) @(negedge clk);
        in_level = '0;
        init_done = 1'b1;

        for (int i = 0; i < BPF; i++) burst_w(0, i / 2, (i % 2) * 256, i == BPF - 1);
        for (int i = 0; i < BPF; i++) burst_r(2, i / 2, (i % 2) * 256, i == BPF - 1);
        chk("repeat_after_switch", 64'(repeat_cnt), 0);
        for (int i = 0; i < BPF; i++) burst_r(0, i / 2, (i % 2) * 256, i == BPF - 1);
        chk("repeat_after_reshow", 64'(repeat_cnt), 1);

        push(0, 1, 0, 0);
        push(1, 0, 0, 0);
        push(0, 1, 0, 256);
        in_level = 10'd300;
        out_level = 10'd200;
        wait_reqs(3);
        in_level = '0;
        out_level = 10'd400;
        repeat (busy_len + 12) @(negedge clk);

        push(1, 0, 0, 256);
        push(1, 0, 1, 0);
        in_level = 10'd300;
        out_level = 10'd10;
        wait_reqs(2);
        in_level = '0;
        out_level = 10'd400;
        repeat (busy_len + 12) @(negedge clk);

        no_busy = 1'b1;
        push(0, 1, 1, 0);
        in_level = 10'd300;
        wait_reqs(1);
        in_level = '0;
        repeat (TMO + 20) @(negedge clk);
        chk("timeout_set", 64'(timeout_err), 1);
        no_busy = 1'b0;
        burst_w(1, 1, 0, 1'b0);
        burst_w(1, 1, 256, 1'b1);
        burst_r(0, 1, 256, 1'b1);
        chk("repeat_after_rotate", 64'(repeat_cnt), 1);

        burst_w(2, 0, 0, 1'b0);
        burst_w(2, 0, 256, 1'b0);
        wr_frame_sync = 1'b1;
        repeat (6) @(negedge clk);
        wr_frame_sync = 1'b0;
        repeat (6) @(negedge clk);
`ifdef GRAM_FRAME_RESYNC_EN
        burst_w(2, 0, 0, 1'b0);
`else
        burst_w(2, 1, 0, 1'b0);
`endif
        chk("timeout_sticky", 64'(timeout_err), 1);

        busy_len = 4;
        for (int f = 0; f < 300; f++) begin
            for (int i = 0; i < BPF; i++) burst_r(1, i / 2, (i % 2) * 256, i == BPF - 1);
            if (f == 9) chk("repeat_10_more", 64'(repeat_cnt), 11);
        end
        chk("repeat_saturated", 64'(repeat_cnt), 255);

        repeat (5) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
